igbt_gate_drive_ctrl: RTL and testbench

IGBT_GATE_DRIVE_CTRL -- requirements
Module: igbt_gate_drive_ctrl

---
 rtl/igbt_gate_drive_ctrl_if.sv | 25 ++
 rtl/igbt_gate_drive_ctrl.sv | 164 ++++++++++++++++
 tb/tb_igbt_gate_drive_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/igbt_gate_drive_ctrl_if.sv
// Bundle of per-channel gate-drive signals between the pulse logic / driver
// boards (master side) and the gate drive controller (slave side).
interface igbt_gate_drive_ctrl_if #(
   parameter int CH_NUM = 2
);
   logic [CH_NUM-1:0] IGBT_on_EN;
   logic [CH_NUM-1:0] fault_IGBT_driver;
   logic [CH_NUM-1:0] error_IGBT_driver;
   logic [CH_NUM-1:0] clear_fault;
   logic [CH_NUM-1:0] IGBT;
   logic [CH_NUM-1:0] reset_IGBT_driver;
   logic [CH_NUM-1:0] IGBT_status;
   logic [CH_NUM-1:0] fault_latched;
   logic [CH_NUM-1:0] timeout_flag;

   modport master (
      output IGBT_on_EN, fault_IGBT_driver, error_IGBT_driver, clear_fault,
      input  IGBT, reset_IGBT_driver, IGBT_status, fault_latched, timeout_flag
   );

   modport slave (
      input  IGBT_on_EN, fault_IGBT_driver, error_IGBT_driver, clear_fault,
      output IGBT, reset_IGBT_driver, IGBT_status, fault_latched, timeout_flag
   );
endinterface

// File: rtl/igbt_gate_drive_ctrl.sv
// Multi-channel IGBT gate drive controller: per-channel FSM with minimum
// off-time, driver fault latching, driver-board reset pulse and recovery.
// Optional feature macro: IGBT_MAX_ON_TIMEOUT_EN enables the forced turn-off
// after MAX_ON_US of continuous on-time (timeout_flag is tied 0 without it).
module igbt_gate_drive_ctrl #(
   parameter int CH_NUM       = 2,
   parameter int CLK_PER_US   = 50,
   parameter int MAX_ON_US    = 20000,
   parameter int MIN_OFF_US   = 10,
   parameter int RST_PULSE_US = 5
) (
   input logic                   sys_clk,
   input logic                   sys_rst_n,
   igbt_gate_drive_ctrl_if.slave bus
);
   localparam int MAX_T = (MAX_ON_US > MIN_OFF_US) ?
                          ((MAX_ON_US > RST_PULSE_US) ? MAX_ON_US : RST_PULSE_US) :
                          ((MIN_OFF_US > RST_PULSE_US) ? MIN_OFF_US : RST_PULSE_US);
   localparam int CW = $clog2(MAX_T + 1);
   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
   localparam logic [CW-1:0] CNT_SAT    = '1;
   localparam logic [CW-1:0] OFF_LAST   = CW'(MIN_OFF_US - 1);
   localparam logic [CW-1:0] RST_LAST   = CW'(RST_PULSE_US - 1);
`ifdef IGBT_MAX_ON_TIMEOUT_EN
   localparam logic [CW-1:0] ON_LAST    = CW'(MAX_ON_US - 1);
`endif

   typedef enum logic [2:0] {
      IDLE, ON, OFF_WAIT, FAULT, RESET_DRV, RECOVER
   } state_t;

   logic [PW-1:0] presc;
   logic          tick;

   assign tick = (presc == PRESC_LAST);

   // Shared 1 us prescaler, restarts from zero after every tick
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PW'(1);
   end

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      state_t        state;
      state_t        next;
      logic [CW-1:0] cnt;
      logic          flt;
      logic          en;
      logic          igbt_q;
      logic          status_q;
      logic          latch_q;
      logic          drv_rst_q;

      assign flt = bus.fault_IGBT_driver[c] | bus.error_IGBT_driver[c];
      assign en  = bus.IGBT_on_EN[c];

`ifdef IGBT_MAX_ON_TIMEOUT_EN
      logic to_hit;
      logic tflag_q;
`endif

      // Next-state decode; a driver fault wins over everything in the gate states
      always_comb begin
         next = state;
`ifdef IGBT_MAX_ON_TIMEOUT_EN
         to_hit = 1'b0;
`endif
         case (state)
            IDLE: begin
               if (flt)
                  next = FAULT;
               else if (en)
                  next = ON;
            end
            ON: begin
               if (flt)
                  next = FAULT;
               else if (!en)
                  next = OFF_WAIT;
`ifdef IGBT_MAX_ON_TIMEOUT_EN
               else if (tick && (cnt == ON_LAST)) begin
                  next   = FAULT;
                  to_hit = 1'b1;
               end
`endif
            end
            OFF_WAIT: begin
               if (flt)
                  next = FAULT;
               else if (tick && (cnt == OFF_LAST))
                  next = IDLE;
            end
            FAULT: begin
               if (bus.clear_fault[c])
                  next = RESET_DRV;
            end
            RESET_DRV: begin
               if (tick && (cnt == RST_LAST))
                  next = RECOVER;
            end
            RECOVER: begin
               if (!flt && !en)
                  next = IDLE;
            end
            default: next = IDLE;
         endcase
      end

      // State register with outputs registered from the upcoming state
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            state     <= IDLE;
            igbt_q    <= 1'b0;
            status_q  <= 1'b0;
            latch_q   <= 1'b0;
            drv_rst_q <= 1'b0;
         end else begin
            state     <= next;
            igbt_q    <= (next == ON);
            status_q  <= (next == ON);
            latch_q   <= (next == FAULT) || (next == RESET_DRV) || (next == RECOVER);
            drv_rst_q <= (next == RESET_DRV);
         end
      end

      // Microsecond counter: zeroed on entry to a timed state, saturates at full scale
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n)
            cnt <= '0;
         else if ((next != state) &&
                  ((next == ON) || (next == OFF_WAIT) || (next == RESET_DRV)))
            cnt <= '0;
         else if (tick && (cnt != CNT_SAT))
            cnt <= cnt + CW'(1);
      end

`ifdef IGBT_MAX_ON_TIMEOUT_EN
      // Remember whether the latest fault came from the on-time limit
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n)
            tflag_q <= 1'b0;
         else if ((next == FAULT) && (state != FAULT))
            tflag_q <= to_hit;
         else if ((state == RECOVER) && (next == IDLE))
            tflag_q <= 1'b0;
      end

      assign bus.timeout_flag[c] = tflag_q;
`else
      assign bus.timeout_flag[c] = 1'b0;
`endif

      assign bus.IGBT[c]              = igbt_q;
      assign bus.IGBT_status[c]       = status_q;
      assign bus.fault_latched[c]     = latch_q;
      assign bus.reset_IGBT_driver[c] = drv_rst_q;
   end
endmodule

// File: tb/tb_igbt_gate_drive_ctrl.sv
// Testbench for igbt_gate_drive_ctrl: directed scenarios followed by random
// stimulus, all checked against a deadline-based behavioural model.
module tb_igbt_gate_drive_ctrl;
   localparam int CH        = 2;
   localparam int CLK_US    = 50;
   localparam int MAX_ON    = 100;
   localparam int MIN_OFF   = 10;
   localparam int RST_PULSE = 5;

`ifdef IGBT_MAX_ON_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int M_IDLE = 0;
   localparam int M_ON   = 1;
   localparam int M_OFFW = 2;
   localparam int M_FLT  = 3;
   localparam int M_RST  = 4;
   localparam int M_REC  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #10 clk = ~clk;

   igbt_gate_drive_ctrl_if #(.CH_NUM(CH)) bus ();

   igbt_gate_drive_ctrl #(
      .CH_NUM      (CH),
      .CLK_PER_US  (CLK_US),
      .MAX_ON_US   (MAX_ON),
      .MIN_OFF_US  (MIN_OFF),
      .RST_PULSE_US(RST_PULSE)
   ) dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .bus      (bus)
   );

   int total = 0;
   int bad   = 0;

   int mode     [CH];
   int deadline [CH];
   bit tflag    [CH];
   int edgeN;

   logic [CH-1:0] en_v, flt_v, err_v, clr_v;

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [CH-1:0] got,
                              input logic [CH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   // Edge index (counted from reset release) of the n-th microsecond tick after edge e
   function automatic int tickEdge(input int e, input int n);
      return (e / CLK_US + n) * CLK_US;
   endfunction

   function automatic void modelReset();
      for (int c = 0; c < CH; c++) begin
         mode[c]     = M_IDLE;
         deadline[c] = 0;
         tflag[c]    = 1'b0;
      end
      edgeN = 0;
   endfunction

   // Advance the reference by one clock edge using the inputs sampled at that edge
   function automatic void modelStep();
      edgeN++;
      for (int c = 0; c < CH; c++) begin
         int nm;
         bit flt;
         bit en;
         bit tmo;
         nm  = mode[c];
         flt = flt_v[c] | err_v[c];
         en  = en_v[c];
         tmo = 1'b0;
         case (mode[c])
            M_IDLE: if (flt) nm = M_FLT; else if (en) nm = M_ON;
            M_ON: begin
               if (flt) nm = M_FLT;
               else if (!en) nm = M_OFFW;
               else if (TMO_EN && edgeN == deadline[c]) begin
                  nm  = M_FLT;
                  tmo = 1'b1;
               end
            end
            M_OFFW: if (flt) nm = M_FLT; else if (edgeN == deadline[c]) nm = M_IDLE;
            M_FLT:  if (clr_v[c]) nm = M_RST;
            M_RST:  if (edgeN == deadline[c]) nm = M_REC;
            M_REC: begin
               if (!flt && !en) begin
                  nm       = M_IDLE;
                  tflag[c] = 1'b0;
               end
            end
            default: nm = M_IDLE;
         endcase
         if (nm != mode[c]) begin
            if (nm == M_FLT)  tflag[c]    = tmo;
            if (nm == M_ON)   deadline[c] = tickEdge(edgeN, MAX_ON);
            if (nm == M_OFFW) deadline[c] = tickEdge(edgeN, MIN_OFF);
            if (nm == M_RST)  deadline[c] = tickEdge(edgeN, RST_PULSE);
         end
         mode[c] = nm;
      end
   endfunction

   task automatic compareAll();
      logic [CH-1:0] e_igbt, e_lat, e_drv, e_tf;
      e_igbt = '0;
      e_lat  = '0;
      e_drv  = '0;
      e_tf   = '0;
      for (int c = 0; c < CH; c++) begin
         e_igbt[c] = (mode[c] == M_ON);
         e_lat[c]  = (mode[c] == M_FLT) || (mode[c] == M_RST) || (mode[c] == M_REC);
         e_drv[c]  = (mode[c] == M_RST);
         e_tf[c]   = tflag[c];
      end
      checkOutput("IGBT", bus.IGBT, e_igbt);
      checkOutput("IGBT_status", bus.IGBT_status, e_igbt);
      checkOutput("fault_latched", bus.fault_latched, e_lat);
      checkOutput("reset_IGBT_driver", bus.reset_IGBT_driver, e_drv);
      checkOutput("timeout_flag", bus.timeout_flag, e_tf);
   endtask

   // Drive one cycle of inputs, step the model on the edge, check just after it
   task automatic applyStimulus(input logic [CH-1:0] en, input logic [CH-1:0] flt,
                                input logic [CH-1:0] err, input logic [CH-1:0] clr);
      en_v  = en;
      flt_v = flt;
      err_v = err;
      clr_v = clr;
      bus.IGBT_on_EN        = en;
      bus.fault_IGBT_driver = flt;
      bus.error_IGBT_driver = err;
      bus.clear_fault       = clr;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   task automatic runFor(input int n, input logic [CH-1:0] en, input logic [CH-1:0] flt,
                         input logic [CH-1:0] err, input logic [CH-1:0] clr);
      for (int i = 0; i < n; i++)
         applyStimulus(en, flt, err, clr);
   endtask

   task automatic checkAllZero(input string pfx);
      checkOutput({pfx, "_IGBT"}, bus.IGBT, '0);
      checkOutput({pfx, "_IGBT_status"}, bus.IGBT_status, '0);
      checkOutput({pfx, "_fault_latched"}, bus.fault_latched, '0);
      checkOutput({pfx, "_reset_IGBT_driver"}, bus.reset_IGBT_driver, '0);
      checkOutput({pfx, "_timeout_flag"}, bus.timeout_flag, '0);
   endtask

   logic [CH-1:0] en_r, f_r, e_r, c_r;
   int            hold [CH];

   initial begin
      bus.IGBT_on_EN        = '0;
      bus.fault_IGBT_driver = '0;
      bus.error_IGBT_driver = '0;
      bus.clear_fault       = '0;
      #5 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();

      $display("[TB] directed scenarios");
      runFor(5, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b00, 2'b00, 2'b00, 2'b11);
      runFor(5, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(2500, 2'b01, 2'b00, 2'b00, 2'b00);
      runFor(100, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(600, 2'b01, 2'b00, 2'b00, 2'b00);
      runFor(600, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(300, 2'b11, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b11, 2'b10, 2'b00, 2'b00);
      runFor(200, 2'b11, 2'b00, 2'b00, 2'b00);
      runFor(600, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b00, 2'b00, 2'b00, 2'b10);
      runFor(400, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b01, 2'b00, 2'b01, 2'b00);
      runFor(100, 2'b01, 2'b00, 2'b00, 2'b00);
      runFor(10, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b00, 2'b00, 2'b00, 2'b01);
      runFor(400, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(5500, 2'b01, 2'b00, 2'b00, 2'b00);
      runFor(10, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(1, 2'b00, 2'b00, 2'b00, 2'b01);
      runFor(900, 2'b00, 2'b00, 2'b00, 2'b00);
      runFor(200, 2'b11, 2'b00, 2'b00, 2'b00);

      $display("[TB] asynchronous reset while gates are on");
      #4 rst_n = 1'b0;
      #1;
      checkAllZero("async_rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      modelReset();
      runFor(20, 2'b00, 2'b00, 2'b00, 2'b00);

      $display("[TB] random stimulus");
      en_r = '0;
      for (int c = 0; c < CH; c++)
         hold[c] = 0;
      for (int n = 0; n < 40000 && bad <= 20; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (hold[c] == 0) begin
               en_r[c] = ~en_r[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2000, 7000))
                                                     : int'($urandom_range(1, 400));
            end else begin
               hold[c]--;
            end
            f_r[c] = ($urandom_range(0, 2999) == 0);
            e_r[c] = ($urandom_range(0, 2999) == 0);
            c_r[c] = ($urandom_range(0, 99) == 0);
         end
         applyStimulus(en_r, f_r, e_r, c_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
